// File: rtl/lsystem_draw_sequencer.sv
// L-system pass sequencer: clears the frame, walks the selected symbol ROM, issues one line draw per F.
// Turn costs 2 cycles and draw at least 3; clear and draw requests are held until acknowledged, never withdrawn.
module lsystem_draw_sequencer #(
  parameter int SYM_AW    = 12,
  parameter int HEAD_W    = 3,
  parameter int HEAD_INIT = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [2:0]            i_sys_sel,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_clr_req,
  input  logic                  i_clr_done,
  output logic [3+SYM_AW-1:0]   o_sym_addr,
  input  logic [1:0]            i_sym_data,
  output logic                  o_draw_req,
  input  logic                  i_draw_ack,
  output logic [HEAD_W-1:0]     o_draw_heading,
  output logic [CNT_W-1:0]      o_draw_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_DECODE, S_DRAW, S_FIN
  } state_t;

  localparam logic [1:0] SYM_F   = 2'b00;
  localparam logic [1:0] SYM_P   = 2'b01;
  localparam logic [1:0] SYM_END = 2'b11;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_sel_q;
  logic [SYM_AW-1:0]   r_ptr;
  logic [HEAD_W-1:0]   r_heading;
  logic [CNT_W-1:0]    r_draw_count;
  logic                r_done;
  logic                r_err;
  logic                r_abort_pend;

  logic w_abort;
  logic w_accept;
  logic w_ptr_inc;
  logic w_turn_up;
  logic w_turn_dn;
  logic w_cnt_inc;
  logic w_set_err;
  logic w_set_done;

  assign w_abort = i_abort | r_abort_pend;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ptr_inc   = 1'b0;
    w_turn_up   = 1'b0;
    w_turn_dn   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_err   = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (i_clr_done) w_state_nxt = w_abort ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = w_abort ? S_IDLE : S_DECODE;
      end
      S_DECODE: begin
        // abort beats END, and ROM overrun is checked before the symbol acts
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (i_sym_data == SYM_END) begin
          w_state_nxt = S_FIN;
        end else if (&r_ptr) begin
          w_set_err   = 1'b1;
          w_state_nxt = S_FIN;
        end else if (i_sym_data == SYM_F) begin
          w_state_nxt = S_DRAW;
        end else begin
          w_turn_up   = (i_sym_data == SYM_P);
          w_turn_dn   = (i_sym_data != SYM_P);
          w_ptr_inc   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_DRAW: begin
        if (i_draw_ack) begin
          if (w_abort) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_inc   = 1'b1;
            w_ptr_inc   = 1'b1;
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_FIN: begin
        w_set_done  = !r_err;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_sel_q      <= '0;
      r_ptr        <= '0;
      r_heading    <= HEAD_W'(HEAD_INIT);
      r_draw_count <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // pending abort lives only while a pass is running
      r_abort_pend <= w_abort && (r_state != S_IDLE) && (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_sel_q      <= i_sys_sel;
        r_ptr        <= '0;
        r_heading    <= HEAD_W'(HEAD_INIT);
        r_draw_count <= '0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
      end else begin
        if (w_ptr_inc) r_ptr <= r_ptr + SYM_AW'(1);
        if (w_turn_up) r_heading <= r_heading + HEAD_W'(1);
        if (w_turn_dn) r_heading <= r_heading - HEAD_W'(1);
        if (w_cnt_inc && !(&r_draw_count)) r_draw_count <= r_draw_count + CNT_W'(1);
        if (w_set_err) r_err <= 1'b1;
        if (w_set_done) r_done <= 1'b1;
      end
    end
  end

  assign o_busy         = (r_state != S_IDLE);
  assign o_clr_req      = (r_state == S_CLEAR);
  assign o_draw_req     = (r_state == S_DRAW);
  assign o_done         = r_done;
  assign o_err          = r_err;
  assign o_sym_addr     = {r_sel_q, r_ptr};
  assign o_draw_heading = r_heading;
  assign o_draw_count   = r_draw_count;

endmodule

// File: tb/tb_lsystem_draw_sequencer.sv
// Bench for lsystem_draw_sequencer: ROM walk model feeds an expected-draw queue checked at each draw handshake.
module tb_lsystem_draw_sequencer;
  localparam int SYM_AW = 12, HEAD_W = 3, HEAD_INIT = 2, CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort, clr_done, draw_ack;
  logic [2:0]  sys_sel;
  logic        busy, done, err, clr_req, draw_req;
  logic [14:0] sym_addr;
  logic [1:0]  sym_data;
  logic [2:0]  heading;
  logic [15:0] draw_count;

  always #5 clk = ~clk;

  lsystem_draw_sequencer #(.SYM_AW(SYM_AW), .HEAD_W(HEAD_W), .HEAD_INIT(HEAD_INIT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset(rst), .i_sys_sel(sys_sel), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_err(err), .o_clr_req(clr_req), .i_clr_done(clr_done),
    .o_sym_addr(sym_addr), .i_sym_data(sym_data), .o_draw_req(draw_req), .i_draw_ack(draw_ack),
    .o_draw_heading(heading), .o_draw_count(draw_count)
  );

  logic [1:0] rom [0:32767];
  always @(posedge clk) sym_data <= rom[sym_addr];

  typedef struct packed {logic [2:0] h; logic [14:0] a;} exp_t;
  exp_t sb[$];

  int n_checks = 0, n_err = 0;
  int ack_delay = 0, clr_delay = 3;
  int clr_hi = 0, clr_len = 0, dr_hi = 0, dr_len = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // clear engine and line drawer responders
  initial begin
    clr_done = 1'b0;
    draw_ack = 1'b0;
    forever begin
      @(negedge clk);
      draw_ack = 1'b0;
      if (clr_req) begin
        clr_hi++;
        clr_len  = clr_hi;
        clr_done = (clr_hi == clr_delay);
      end else begin
        clr_hi   = 0;
        clr_done = 1'b0;
      end
      if (draw_req) begin
        dr_hi++;
        dr_len = dr_hi;
        if (dr_hi == ack_delay + 1) begin
          draw_ack = 1'b1;
          if (sb.size() == 0) begin
            check_eq("draw_unexpected", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("draw_heading", heading, e.h);
            check_eq("draw_addr", sym_addr, e.a);
          end
        end
      end else begin
        dr_hi = 0;
      end
    end
  end

  task automatic model_pass(input logic [2:0] sel, output int cnt, output bit e_err);
    logic [2:0] h;
    logic [1:0] s;
    exp_t e;
    h = 3'(HEAD_INIT);
    cnt = 0;
    e_err = 1'b0;
    for (int p = 0; p < 4096; p++) begin
      s = rom[{sel, p[11:0]}];
      if (s == 2'b11) break;
      if (p == 4095) begin
        e_err = 1'b1;
        break;
      end
      if (s == 2'b00) begin
        e.h = h;
        e.a = {sel, p[11:0]};
        sb.push_back(e);
        cnt++;
      end else if (s == 2'b01) begin
        h = h + 3'd1;
      end else begin
        h = h - 3'd1;
      end
    end
  endtask

  task automatic start_pass(input logic [2:0] sel);
    sys_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_eq("timeout_idle", busy, 0);
  endtask

  task automatic wait_draw(input int budget);
    int n;
    n = 0;
    while (!draw_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!draw_req) check_eq("timeout_draw", draw_req, 1);
  endtask

  task automatic run_pass(input logic [2:0] sel, input string tag);
    int  cnt;
    bit  e_err;
    model_pass(sel, cnt, e_err);
    clr_len = 0;
    start_pass(sel);
    check_eq({tag, "_busy"}, busy, 1);
    wait_idle(20000);
    check_eq({tag, "_done"}, done, !e_err);
    check_eq({tag, "_err"}, err, e_err);
    check_eq({tag, "_count"}, draw_count, cnt);
    check_eq({tag, "_clr_len"}, clr_len, clr_delay);
    check_eq({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    int  cnt, n;
    bit  e_err;
    exp_t e;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sys_sel = 3'd0;
    for (int i = 0; i < 32768; i++) rom[i] = 2'b11;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_clr_req", clr_req, 0);
    check_eq("rst_draw_req", draw_req, 0);
    check_eq("rst_heading", heading, 2);
    check_eq("rst_count", draw_count, 0);
    check_eq("rst_addr", sym_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // F + F END on system 5
    rom[15'h5000] = 2'b00; rom[15'h5001] = 2'b01; rom[15'h5002] = 2'b00; rom[15'h5003] = 2'b11;
    run_pass(3'd5, "sys5");
    check_eq("sys5_final_addr", sym_addr, 15'h5003);

    // - - - F END: heading wraps 2 -> 7
    rom[15'h1000] = 2'b10; rom[15'h1001] = 2'b10; rom[15'h1002] = 2'b10;
    rom[15'h1003] = 2'b00; rom[15'h1004] = 2'b11;
    run_pass(3'd1, "wrap");

    // start storm with a different select during the pass
    rom[15'h2000] = 2'b01; rom[15'h2001] = 2'b00; rom[15'h2002] = 2'b10;
    rom[15'h2003] = 2'b00; rom[15'h2004] = 2'b11;
    model_pass(3'd2, cnt, e_err);
    start_pass(3'd2);
    n = 0;
    while (clr_req && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 200) begin
      sys_sel = 3'd6;
      start = 1'b1;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_idle(100);
    check_eq("storm_done", done, 1);
    check_eq("storm_err", err, 0);
    check_eq("storm_count", draw_count, cnt);
    check_eq("storm_addr", sym_addr, 15'h2004);
    check_eq("storm_sb_left", sb.size(), 0);

    // abort in IDLE and start+abort together are both ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("idle_abort_busy", busy, 0);
    check_eq("idle_abort_done", done, 1);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("start_abort_busy", busy, 0);
    check_eq("start_abort_done", done, 1);

    // abort while draw_req held, ack 5 cycles late
    rom[15'h3000] = 2'b00; rom[15'h3001] = 2'b00; rom[15'h3002] = 2'b11;
    ack_delay = 5;
    e.h = 3'd2; e.a = 15'h3000;
    sb.push_back(e);
    start_pass(3'd3);
    wait_draw(50);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(100);
    ack_delay = 0;
    check_eq("abort_req_len", dr_len, 6);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_err", err, 0);
    check_eq("abort_count", draw_count, 0);
    check_eq("abort_sb_left", sb.size(), 0);

    // system 7 has no END: overrun after 4095 draws
    for (int i = 0; i < 4096; i++) rom[15'h7000 + i] = 2'b00;
    run_pass(3'd7, "overrun");
    check_eq("overrun_addr", sym_addr, 15'h7FFF);

    // asynchronous reset while draw_req is held
    rom[15'h4000] = 2'b01; rom[15'h4001] = 2'b00; rom[15'h4002] = 2'b11;
    ack_delay = 1000;
    start_pass(3'd4);
    wait_draw(50);
    check_eq("pre_rst_heading", heading, 3);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_draw_req", draw_req, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_heading", heading, 2);
    check_eq("arst_err", err, 0);
    check_eq("arst_count", draw_count, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 0;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/lsystem_draw_sequencer.md
Name: lsystem_draw_sequencer

Overview:
Sequences one L-system rendering pass. The 3-bit system select comes from the HPS-written lsystem PIO. The block clears the frame through the screen-clear engine, then walks that system's symbol ROM. It issues one line-draw request per draw symbol to the line drawer and tracks turtle heading for turn symbols. It sits between the Avalon PIO outputs and the SRAM drawing engines.

Parameters:
SYM_AW, 12, symbol ROM offset width per system (4096 symbols max)
HEAD_W, 3, heading width (2^HEAD_W directions, wrap modulo)
HEAD_INIT, 2, heading loaded at every start
CNT_W, 16, draw_count width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sys_sel  in  3  L-system select (PIO out_port)
start  in  1  single-cycle start pulse
abort  in  1  single-cycle abort pulse
busy  out  1  high in any state except IDLE
done  out  1  sticky; set on normal completion, cleared by accepted start
err  out  1  sticky; set on ROM overrun, cleared by accepted start
clr_req  out  1  screen-clear request, held until clr_done
clr_done  in  1  clear engine completion pulse
sym_addr  out  3+SYM_AW  {sel_q, ptr} to symbol ROM
sym_data  in  2  ROM data, valid the cycle after sym_addr is presented
draw_req  out  1  line-draw request, held until draw_ack
draw_ack  in  1  line drawer accept pulse
draw_heading  out  HEAD_W  heading for the current segment, stable while draw_req=1
draw_count  out  CNT_W  segments drawn this pass, saturating

Behaviour:
- Reset: state=IDLE; busy, done, err, clr_req, draw_req = 0; ptr=0, sel_q=0, heading=HEAD_INIT, draw_count=0. Reset mid-pass drops all requests immediately.
- Symbol encoding: 00 F (draw), 01 + (heading+1), 10 - (heading-1), 11 END. Heading wraps modulo 2^HEAD_W.
- States: IDLE, CLEAR, FETCH, DECODE, DRAW, FIN.
- IDLE:
  - start=1 and abort=0: latch sel_q<=sys_sel; ptr<=0; heading<=HEAD_INIT; draw_count<=0; clear done/err; next CLEAR.
  - start with abort=1 in the same cycle: ignored.
  - start while not IDLE: ignored, no effect on latched sel_q.
- CLEAR: clr_req=1. On clr_done=1, clr_req drops next cycle; next FETCH.
- FETCH: sym_addr={sel_q,ptr} is driven in every state and updates only on ptr change. Next DECODE.
- DECODE: sym_data valid.
  - F: next DRAW.
  - + or -: update heading, ptr+1, next FETCH.
  - END: next FIN.
  - Any non-END symbol with ptr all-ones: set err, next FIN. The F is not drawn and the turn is not applied.
- DRAW: draw_req=1, draw_heading=heading.
  - On draw_ack=1: draw_req drops next cycle; draw_count+1, saturating at all-ones; ptr+1; next FETCH.
  - draw_ack is ignored in every other state.
- FIN: single cycle; set done only if err is not being set; next IDLE. busy falls the cycle after FIN.
- Per-symbol cost: turn = 2 cycles; draw = 2 cycles + handshake (minimum 3 if ack arrives in the first DRAW cycle).
- Abort:
  - Latched into abort_pend.
  - In FETCH/DECODE: taken immediately to IDLE.
  - In CLEAR or DRAW: pending until clr_done/draw_ack completes the handshake, then IDLE. No request is withdrawn unacknowledged.
  - Aborted pass sets neither done nor err. draw_count holds its value.
  - abort in IDLE: no effect.
- Simultaneous abort and END decode: abort wins, done not set.

Test Plan:
- Reset asserted mid-DRAW with draw_req=1 -> draw_req=0, busy=0, heading=2 in the same cycle as reset (asynchronous).
- sys_sel=5, ROM[5] = F,+,F,END, acks immediate, clr_done 3 cycles after clr_req -> sym_addr 0x5000..0x5003; draw_heading 2 then 3; draw_count=2; done=1, err=0; clr_req high exactly 3 cycles.
- ROM = -,-,-,F,END from HEAD_INIT=2 -> heading wraps to 7; one draw with draw_heading=7; done=1.
- Abort while draw_req=1 and ack delayed 5 cycles -> draw_req held until ack, then IDLE; done=0, err=0, draw_count unchanged.
- ROM segment with no END (all F), immediate acks -> 4095 draws; err=1, done=0 when ptr=0xFFF decodes.
- start pulsed during DECODE with a different sys_sel -> ignored, sel_q unchanged, pass completes normally.
